init_cmd_queue: RTL and testbench

INIT_CMD_QUEUE -- requirements
Module: init_cmd_queue

---
 rtl/init_cmd_queue.sv | 179 +++++++++++++++++
 tb/tb_init_cmd_queue.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_cmd_queue.sv
// init_cmd_queue: queues bus commands in a small FIFO and replays them one at a time
// through a request/grant/address/ack initiator handshake, reporting each completion
// as a single-cycle response pulse.
// Optional build macro INIT_CMD_QUEUE_TIMEOUT_EN adds an 8-bit watchdog that aborts a
// stalled transaction with rsp_err=1; without it the FSM waits indefinitely.
module init_cmd_queue #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [15:0]            cmd_addr,
    input  logic [7:0]             cmd_wdata,
    output logic                   init_req,
    input  logic                   init_grant,
    output logic [15:0]            init_addr_out,
    output logic                   init_addr_out_valid,
    output logic [7:0]             init_data_out,
    output logic                   init_data_out_valid,
    output logic                   init_rw,
    output logic                   init_ready,
    input  logic                   init_ack,
    input  logic                   init_split_ack,
    input  logic [7:0]             init_data_in,
    input  logic                   init_data_in_valid,
    output logic                   rsp_valid,
    output logic                   rsp_rw,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, WAIT_ACK, WAIT_DATA, RESP} state_t;

    state_t        state;
    logic [24:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [24:0]   head;
    logic          push;
    logic          pop;
    logic          cur_rw;
    logic [15:0]   cur_addr;
    logic [7:0]    cur_wdata;
    logic          wd_hit;
    logic          done;
    logic [7:0]    done_data;

    assign cmd_ready = level < FULL;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (level != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (level != '0);

    // Storage array; entries are {rw, addr, wdata} and need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
    end

    // Pointers wrap naturally since DEPTH is a power of two; push+pop keeps level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Transaction completion: watchdog, write ack, or read data in a read-wait state.
    always_comb begin
        done      = wd_hit
                 || (state == WAIT_ACK && (cur_rw ? init_ack : init_data_in_valid))
                 || (state == WAIT_DATA && init_data_in_valid);
        done_data = (wd_hit || cur_rw) ? 8'h00 : init_data_in;
    end

    // Initiator FSM with registered outputs set on each transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cur_rw              <= 1'b0;
            cur_addr            <= '0;
            cur_wdata           <= '0;
            init_req            <= 1'b0;
            init_rw             <= 1'b0;
            init_ready          <= 1'b0;
            init_addr_out       <= '0;
            init_addr_out_valid <= 1'b0;
            init_data_out       <= '0;
            init_data_out_valid <= 1'b0;
            rsp_valid           <= 1'b0;
            rsp_rw              <= 1'b0;
            rsp_rdata           <= '0;
        end else begin
            init_addr_out_valid <= 1'b0;
            init_data_out_valid <= 1'b0;
            rsp_valid           <= 1'b0;
            if (done) begin
                state      <= RESP;
                init_req   <= 1'b0;
                init_rw    <= 1'b0;
                init_ready <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_rw     <= cur_rw;
                rsp_rdata  <= done_data;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            state                          <= REQ;
                            {cur_rw, cur_addr, cur_wdata} <= head;
                            init_req                       <= 1'b1;
                            init_rw                        <= head[24];
                        end
                    end
                    REQ: begin
                        if (init_grant) begin
                            state               <= ADDR;
                            init_addr_out       <= cur_addr;
                            init_addr_out_valid <= 1'b1;
                            if (cur_rw) begin
                                init_data_out       <= cur_wdata;
                                init_data_out_valid <= 1'b1;
                            end
                        end
                    end
                    ADDR: begin
                        state      <= WAIT_ACK;
                        init_ready <= !cur_rw;
                    end
                    WAIT_ACK: begin
                        if (!cur_rw && init_split_ack) state <= WAIT_DATA;
                    end
                    RESP: begin
                        state     <= IDLE;
                        rsp_rw    <= 1'b0;
                        rsp_rdata <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef INIT_CMD_QUEUE_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;
    logic       wd_run;

    assign wd_run = (state == REQ) || (state == WAIT_ACK) || (state == WAIT_DATA);
    assign wd_hit = wd_run && (wd_cnt == WD_LAST);

    // Watchdog restarts in IDLE so it reads zero on REQ entry; rsp_err lines up with RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            rsp_err <= 1'b0;
        end else begin
            wd_cnt  <= (state == IDLE) ? 8'd0 : wd_run ? wd_cnt + 8'd1 : wd_cnt;
            rsp_err <= wd_hit;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_init_cmd_queue.sv
// tb_init_cmd_queue: scoreboard bench with a randomized bus responder for init_cmd_queue.
module tb_init_cmd_queue;
    localparam int DEPTH = 4;
    localparam int TO    = 255;

    typedef struct packed { logic rw; logic [15:0] addr; logic [7:0] wdata; } addr_t;
    typedef struct packed { logic rw; logic [7:0] rdata; logic err; } rsp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic                   cmd_rw = 1'b0;
    logic [15:0]            cmd_addr = '0;
    logic [7:0]             cmd_wdata = '0;
    logic                   init_req;
    logic                   init_grant = 1'b0;
    logic [15:0]            init_addr_out;
    logic                   init_addr_out_valid;
    logic [7:0]             init_data_out;
    logic                   init_data_out_valid;
    logic                   init_rw;
    logic                   init_ready;
    logic                   init_ack = 1'b0;
    logic                   init_split_ack = 1'b0;
    logic [7:0]             init_data_in = '0;
    logic                   init_data_in_valid = 1'b0;
    logic                   rsp_valid;
    logic                   rsp_rw;
    logic [7:0]             rsp_rdata;
    logic                   rsp_err;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    rsp_seen = 0;
    int    addr_seen = 0;
    addr_t exp_a[$];
    rsp_t  exp_r[$];
    bit    hold_grant = 0;
    bit    expect_to = 0;
    int    fix_gdly = -1;
    int    fix_rdly = -1;
    int    fix_mode = -1;
    int    fix_ddly = -1;
    int    rphase = 0;

    init_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .init_req(init_req), .init_grant(init_grant),
        .init_addr_out(init_addr_out), .init_addr_out_valid(init_addr_out_valid),
        .init_data_out(init_data_out), .init_data_out_valid(init_data_out_valid),
        .init_rw(init_rw), .init_ready(init_ready),
        .init_ack(init_ack), .init_split_ack(init_split_ack),
        .init_data_in(init_data_in), .init_data_in_valid(init_data_in_valid),
        .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Read data the bus returns for an address; the model predicts reads from this.
    function automatic logic [7:0] rd_of(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'hD6;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic rw, input logic [15:0] a, input logic [7:0] d, output bit acc);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        acc       = cmd_ready;
        if (acc) begin
            if (expect_to) exp_r.push_back('{rw: rw, rdata: 8'h00, err: 1'b1});
            else begin
                exp_a.push_back('{rw: rw, addr: a, wdata: d});
                exp_r.push_back('{rw: rw, rdata: rw ? 8'h00 : rd_of(a), err: 1'b0});
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((exp_a.size() != 0 || exp_r.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_a.size() != 0 || exp_r.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_r.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({init_req, init_addr_out_valid, init_data_out_valid, init_rw,
                                   init_ready, rsp_valid, rsp_rw, rsp_err, busy}), 32'd0);
        check({tag, "_buses"}, 32'({init_addr_out, init_data_out}), 32'd0);
        check({tag, "_rdata"}, 32'(rsp_rdata), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        exp_a.delete();
        exp_r.delete();
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bus target: grants, acks and returns read data with random or pinned delays.
    initial begin : responder
        int          cnt;
        int          mode;
        logic        trw;
        logic [15:0] taddr;
        cnt = 0; mode = 0; trw = 1'b0; taddr = '0;
        forever begin
            @(negedge clk);
            init_grant = 1'b0; init_ack = 1'b0; init_split_ack = 1'b0;
            init_data_in_valid = 1'b0; init_data_in = 8'h00;
            if (!rst_n) rphase = 0;
            else case (rphase)
                0, 1: begin
                    if ($urandom_range(0, 3) == 0) begin
                        init_data_in_valid = 1'b1;
                        init_data_in = 8'($urandom);
                    end
                    if (rphase == 0) begin
                        if (init_req && !hold_grant) begin
                            cnt = fix_gdly >= 0 ? fix_gdly : $urandom_range(0, 3);
                            rphase = 1;
                        end
                    end else if (!hold_grant) begin
                        if (cnt == 0) begin init_grant = 1'b1; rphase = 2; end
                        else cnt--;
                    end
                end
                2: if (init_addr_out_valid) begin
                    trw   = init_rw;
                    taddr = init_addr_out;
                    cnt   = fix_rdly >= 0 ? fix_rdly : $urandom_range(0, 5);
                    mode  = fix_mode >= 0 ? fix_mode : $urandom_range(0, 2);
                    rphase = 3;
                end
                3: begin
                    if (cnt > 0) begin
                        cnt--;
                        if (trw && $urandom_range(0, 2) == 0) begin
                            init_data_in_valid = 1'b1;
                            init_data_in = 8'($urandom);
                        end
                    end else if (trw) begin
                        init_ack = 1'b1; rphase = 0;
                    end else if (mode == 0) begin
                        init_data_in_valid = 1'b1; init_data_in = rd_of(taddr); rphase = 0;
                    end else begin
                        if (mode == 1) init_split_ack = 1'b1;
                        else init_ack = 1'b1;
                        cnt = fix_ddly >= 0 ? fix_ddly : $urandom_range(0, 4);
                        rphase = 4;
                    end
                end
                4: begin
                    if (cnt > 0) cnt--;
                    else begin
                        init_data_in_valid = 1'b1; init_data_in = rd_of(taddr); rphase = 0;
                    end
                end
                default: rphase = 0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every address strobe and response pulse.
    initial begin : monitor
        bit rd_wait;
        rd_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_wait = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                rsp_seen++;
                rd_wait = 1'b0;
                if (exp_r.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got rw=%0b rdata=%0h err=%0b, required none", rsp_rw, rsp_rdata, rsp_err);
                end else begin
                    rsp_t e;
                    e = exp_r.pop_front();
                    check("rsp_rw", 32'(rsp_rw), 32'(e.rw));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            check("init_ready", 32'(init_ready), 32'(rd_wait));
            check("cmd_ready_rule", 32'(cmd_ready), 32'(level < DEPTH));
            if (init_addr_out_valid) begin
                addr_seen++;
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_addr_strobe: got addr=%0h, required none", init_addr_out);
                end else begin
                    addr_t e;
                    e = exp_a.pop_front();
                    check("addr", 32'(init_addr_out), 32'(e.addr));
                    check("addr_rw", 32'(init_rw), 32'(e.rw));
                    check("addr_req", 32'(init_req), 32'd1);
                    check("data_strobe", 32'(init_data_out_valid), 32'(e.rw));
                    if (e.rw) check("wdata", 32'(init_data_out), 32'(e.wdata));
                    rd_wait = !e.rw;
                end
            end
        end
    end

    initial begin : stimulus
        bit acc;
        int n;
        int r0;
        int acc_cnt;
        int t0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Single write: grant after 2 cycles, ack 5 cycles after the strobe.
        fix_gdly = 2; fix_rdly = 5;
        r0 = rsp_seen; n = addr_seen;
        push_cmd(1'b1, 16'h800A, 8'h5C, acc);
        drain(200, "write");
        check("write_rsp_count", 32'(rsp_seen - r0), 32'd1);
        check("write_strobe_count", 32'(addr_seen - n), 32'd1);

        // Single read with split: data arrives a few cycles after the split ack.
        fix_rdly = 1; fix_mode = 1; fix_ddly = 3;
        r0 = rsp_seen;
        push_cmd(1'b0, 16'h800A, 8'h00, acc);
        drain(200, "split_read");
        check("read_rsp_count", 32'(rsp_seen - r0), 32'd1);
        fix_gdly = -1; fix_rdly = -1; fix_mode = -1; fix_ddly = -1;

        // Fill while grant withheld: one command in flight, four queued, the rest dropped.
        hold_grant = 1; acc_cnt = 0; r0 = rsp_seen;
        for (int i = 0; i < 6; i++) begin
            push_cmd(i[0], 16'h1000 + 16'(i), 8'hA0 + 8'(i), acc);
            acc_cnt += int'(acc);
        end
        check("full_level", 32'(level), 32'd4);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_accepted", 32'(acc_cnt), 32'd5);
        check("full_busy", 32'(busy), 32'd1);
        hold_grant = 0;
        drain(400, "full");
        check("full_rsp_count", 32'(rsp_seen - r0), 32'd5);

        // Simultaneous push and pop at level 2, then pointer wrap over 10 commands.
        hold_grant = 1;
        for (int i = 0; i < 3; i++) push_cmd(1'b1, 16'h2000 + 16'(i), 8'(i), acc);
        check("pp_level_before", 32'(level), 32'd2);
        hold_grant = 0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("pp_first_rsp_seen", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        push_cmd(1'b0, 16'h2003, 8'h00, acc);
        check("pp_level_after", 32'(level), 32'd2);
        for (int i = 0; i < 10; i++) push_cmd(1'($urandom), 16'($urandom), 8'($urandom), acc);
        drain(800, "wrap");

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            push_cmd(1'($urandom), 16'($urandom), 8'($urandom), acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(3000, "random");

        // Grant never given.
        hold_grant = 1;
`ifdef INIT_CMD_QUEUE_TIMEOUT_EN
        expect_to = 1;
        push_cmd(1'b1, 16'h3000, 8'h11, acc);
        expect_to = 0;
        n = 0;
        while (!init_req && n < 10) begin @(negedge clk); n++; end
        t0 = cyc; n = 0;
        while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
        check("timeout_latency", 32'(cyc - t0), 32'(TO));
        drain(20, "timeout");
        hold_grant = 0;
`else
        r0 = rsp_seen;
        push_cmd(1'b1, 16'h3000, 8'h11, acc);
        repeat (1000) @(negedge clk);
        t0 = rsp_seen - r0;
        check("no_timeout_rsp", 32'(t0), 32'd0);
        check("no_timeout_req", 32'(init_req), 32'd1);
        hold_grant = 0;
        apply_reset();
`endif

        // Reset while waiting for split read data with two commands queued.
        fix_rdly = 0; fix_mode = 1; fix_ddly = 40;
        for (int i = 0; i < 3; i++) push_cmd(1'b0, 16'h4000 + 16'(i), 8'h00, acc);
        n = 0;
        while (rphase != 4 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        check("wd_level", 32'(level), 32'd2);
        check("wd_init_ready", 32'(init_ready), 32'd1);
        r0 = rsp_seen;
        apply_reset();
        repeat (60) @(negedge clk);
        check("post_reset_rsp", 32'(rsp_seen - r0), 32'd0);
        check("post_reset_level", 32'(level), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
